// File: rtl/jt51_acc_sched.sv
// jt51_acc_sched: 32-slot operator sequencer with per-channel pan/connection store and frame-aligned noise enable.
module jt51_acc_sched #(
  parameter int DELAY = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       sync_in,
  input  logic       cfg_we,
  input  logic [2:0] cfg_ch,
  input  logic [1:0] cfg_rl,
  input  logic [2:0] cfg_con,
  input  logic       cfg_ne_we,
  input  logic       cfg_ne,
  output logic [4:0] slot,
  output logic       m1_enters,
  output logic       m2_enters,
  output logic       c1_enters,
  output logic       c2_enters,
  output logic       op31_acc,
  output logic [2:0] ch,
  output logic [1:0] rl_I,
  output logic [2:0] con_I,
  output logic       ne,
  output logic       sample
);
  localparam logic [4:0] DL = 5'(DELAY);
  logic [4:0] cnt, cnt_nx, a_nx, a_ld;
  logic [4:0] tbl [8];
  logic       ne_pend;
  assign cnt_nx = sync_in ? 5'd0 : cnt + 5'd1;
  assign a_nx   = cnt_nx - DL;
  assign a_ld   = rst ? 5'd0 - DL : a_nx;
  assign slot   = cnt;
  always_ff @(posedge clk) begin
    if (rst) cnt <= 5'd0;
    else if (cen) cnt <= cnt_nx;
  end
  always_ff @(posedge clk) begin
    if (rst || cen) begin
      {c2_enters, c1_enters, m2_enters, m1_enters} <= 4'b1 << a_ld[4:3];
      ch       <= a_ld[2:0];
      op31_acc <= a_ld == 5'd31;
      sample   <= a_ld == 5'd17;
    end
  end
  // table read happens before this edge's write lands: old value is shown
  always_ff @(posedge clk) begin
    if (rst) {rl_I, con_I} <= 5'b11000;
    else if (cen) {rl_I, con_I} <= tbl[a_nx[2:0]];
  end
  always_ff @(posedge clk) begin
    if (rst) for (int i = 0; i < 8; i++) tbl[i] <= 5'b11000;
    else if (cfg_we) tbl[cfg_ch] <= {cfg_rl, cfg_con};
  end
  always_ff @(posedge clk) begin
    if (rst) ne_pend <= 1'b0;
    else if (cfg_ne_we) ne_pend <= cfg_ne;
  end
  // noise only changes at the frame boundary of the accumulated slot
  always_ff @(posedge clk) begin
    if (rst) ne <= 1'b0;
    else if (cen && a_nx == 5'd0) ne <= cfg_ne_we ? cfg_ne : ne_pend;
  end
endmodule

// File: tb/tb_jt51_acc_sched.sv
// tb_jt51_acc_sched: drives DELAY=0 and DELAY=3 instances in parallel against a slot-level reference model.
module tb_jt51_acc_sched;
  logic clk = 0, rst, cen, sync_in, cfg_we, cfg_ne_we, cfg_ne;
  logic [2:0] cfg_ch, cfg_con;
  logic [1:0] cfg_rl;
  logic [4:0] slot0, slot3;
  logic m1_0, m2_0, c1_0, c2_0, op_0, ne_0, smp_0, m1_3, m2_3, c1_3, c2_3, op_3, ne_3, smp_3;
  logic [2:0] ch_0, con_0, ch_3, con_3;
  logic [1:0] rl_0, rl_3;
  int n_chk = 0, n_fail = 0;
  int m_cnt;
  int m_rl[8], m_con[8];
  int m_pend;
  int m_ne[2], m_orl[2], m_ocon[2];
  int dly[2] = '{0, 3};

  always #5 clk = ~clk;

  jt51_acc_sched #(.DELAY(0)) u0 (.clk(clk), .rst(rst), .cen(cen), .sync_in(sync_in),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_rl(cfg_rl), .cfg_con(cfg_con), .cfg_ne_we(cfg_ne_we),
    .cfg_ne(cfg_ne), .slot(slot0), .m1_enters(m1_0), .m2_enters(m2_0), .c1_enters(c1_0),
    .c2_enters(c2_0), .op31_acc(op_0), .ch(ch_0), .rl_I(rl_0), .con_I(con_0), .ne(ne_0), .sample(smp_0));
  jt51_acc_sched #(.DELAY(3)) u3 (.clk(clk), .rst(rst), .cen(cen), .sync_in(sync_in),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_rl(cfg_rl), .cfg_con(cfg_con), .cfg_ne_we(cfg_ne_we),
    .cfg_ne(cfg_ne), .slot(slot3), .m1_enters(m1_3), .m2_enters(m2_3), .c1_enters(c1_3),
    .c2_enters(c2_3), .op31_acc(op_3), .ch(ch_3), .rl_I(rl_3), .con_I(con_3), .ne(ne_3), .sample(smp_3));

  task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] exp_vec(input int i);
    int a, g;
    a = (m_cnt - dly[i] + 32) % 32;
    g = a / 8;
    return {5'(m_cnt), g == 3, g == 2, g == 1, g == 0, a == 31, 3'(a % 8),
            2'(m_orl[i]), 3'(m_ocon[i]), m_ne[i] != 0, a == 17};
  endfunction

  function automatic logic [19:0] dut_vec(input int i);
    return i == 0 ? {slot0, c2_0, c1_0, m2_0, m1_0, op_0, ch_0, rl_0, con_0, ne_0, smp_0}
                  : {slot3, c2_3, c1_3, m2_3, m1_3, op_3, ch_3, rl_3, con_3, ne_3, smp_3};
  endfunction

  task automatic model_edge();
    int nc, an;
    if (rst) begin
      m_cnt = 0; m_pend = 0;
      for (int k = 0; k < 8; k++) begin m_rl[k] = 3; m_con[k] = 0; end
      for (int i = 0; i < 2; i++) begin m_ne[i] = 0; m_orl[i] = 3; m_ocon[i] = 0; end
      return;
    end
    if (cen) begin
      nc = sync_in ? 0 : (m_cnt + 1) % 32;
      for (int i = 0; i < 2; i++) begin
        an = (nc - dly[i] + 32) % 32;
        m_orl[i] = m_rl[an % 8];
        m_ocon[i] = m_con[an % 8];
        if (an == 0) m_ne[i] = cfg_ne_we ? int'(cfg_ne) : m_pend;
      end
      m_cnt = nc;
    end
    if (cfg_we) begin m_rl[cfg_ch] = cfg_rl; m_con[cfg_ch] = cfg_con; end
    if (cfg_ne_we) m_pend = cfg_ne;
  endtask

  task automatic step(input bit r, input bit c, input bit s, input bit w, input int wch,
                      input int wrl, input int wcon, input bit nw, input bit nv);
    rst = r; cen = c; sync_in = s; cfg_we = w; cfg_ch = 3'(wch); cfg_rl = 2'(wrl);
    cfg_con = 3'(wcon); cfg_ne_we = nw; cfg_ne = nv;
    @(posedge clk);
    model_edge();
    #1;
    chk("vec_d0", dut_vec(0), exp_vec(0));
    chk("vec_d3", dut_vec(1), exp_vec(1));
  endtask

  task automatic tick();
    step(0, 1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic run_to(input int target);
    int n = 0;
    while (m_cnt != target && n < 64) begin tick(); n++; end
    chk("run_to_bound", 20'(m_cnt), 20'(target));
  endtask

  initial begin
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 1, 5, 0, 5, 1, 1);
    chk("rst_slot", 20'(slot0), 20'd0);
    chk("rst_strobes", 20'({m1_0, m2_0, c1_0, c2_0, op_0, smp_0}), 20'b100000);
    chk("rst_cfg", 20'({ch_0, rl_0, con_0, ne_0}), 20'b000_11_000_0);
    chk("rst_d3_grp", 20'({c2_3, ch_3}), 20'b1_101);
    // free run
    for (int i = 0; i < 40; i++) begin
      tick();
      chk("free_m1", 20'(m1_0), 20'(slot0 < 8));
    end
    run_to(3);
    chk("d3_slot3", 20'({m1_3, ch_3}), 20'b1_000);
    run_to(2);
    chk("d3_slot2", 20'({c2_3, op_3}), 20'b11);
    run_to(20);
    chk("d3_sample", 20'(smp_3), 20'd1);
    // config write at slot 10
    run_to(10);
    step(0, 1, 0, 1, 5, 1, 7, 0, 0);
    run_to(13);
    chk("cfg_ch5", 20'({ch_0, rl_0, con_0}), 20'b101_01_111);
    tick();
    chk("cfg_ch6", 20'({rl_0, con_0}), 20'b11_000);
    // collision: write ch2 on the edge where ch becomes 2
    run_to(1);
    step(0, 1, 0, 1, 2, 3, 4, 0, 0);
    chk("coll_old", 20'({ch_0, con_0}), 20'b010_000);
    for (int i = 0; i < 8; i++) tick();
    chk("coll_new", 20'({ch_0, con_0}), 20'b010_100);
    // noise enable
    run_to(4);
    step(0, 1, 0, 0, 0, 0, 0, 1, 1);
    run_to(31);
    chk("ne_hold", 20'(ne_0), 20'd0);
    tick();
    chk("ne_rise", 20'(ne_0), 20'd1);
    run_to(20);
    step(0, 1, 1, 0, 0, 0, 0, 0, 0);
    chk("sync", 20'({slot0, m1_0}), 20'b00000_1);
    // random traffic with sparse cen
    for (int i = 0; i < 300; i++)
      step(0, $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 7),
           $urandom_range(0, 9) == 0, $urandom_range(0, 1) != 0);
    // reset mid-frame
    for (int i = 0; i < 8; i++) step(0, 1, 0, 1, i, i % 4, 7 - i, 1, 1);
    run_to(27);
    step(1, 1, 0, 1, 1, 0, 6, 1, 1);
    chk("rst2_out", 20'({slot0, m1_0, op_0, smp_0, ch_0, rl_0, con_0, ne_0}), 20'b00000_100_000_11_000_0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("rst2_tbl", 20'({rl_0, con_0}), 20'b11_000);
    end
    // cen every other cycle; held outputs are checked by the model on idle cycles
    for (int i = 0; i < 160; i++)
      step(0, i % 2 == 0, 0, $urandom_range(0, 4) == 0, $urandom_range(0, 7),
           $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 15) == 0, $urandom_range(0, 1) != 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
